swap_sched: RTL

Controller for the two-register exchange datapath (registers A and B, swapped in parallel on a clock edge). Two requesters share the datapath through a round-robin arbiter with valid/ready handshakes. Each granted command loads A, loads B, clears both, or runs N back-to-back parallel swaps. An FSM sequences the command and reports completion with a one-cycle done pulse.

---
 rtl/swap_sched_pkg.sv | 19 +
 rtl/swap_sched_if.sv | 36 +++
 rtl/swap_sched_rr_arb2.sv | 17 +
 rtl/swap_sched.sv | 115 +++++++++++
 4 files changed

// File: rtl/swap_sched_pkg.sv
// rtl/swap_sched_pkg.sv - shared op and FSM state encodings for swap_sched
// Purpose: command opcodes and controller states used by the top and the bench.
// Ports: none (package).
package swap_sched_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'b00,
        OP_LOAD_B = 2'b01,
        OP_SWAP_N = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/swap_sched_if.sv
// rtl/swap_sched_if.sv - requester handshakes and status bundle for swap_sched
// Purpose: groups both requester command channels and the datapath/status outputs.
// Ports: reqX_valid/op/data/count (master->slave), reqX_ready, a_out, b_out,
//        busy, done, grant_id (slave->master).
interface swap_sched_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_data;
    logic [CNT_W-1:0] req0_count;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_data;
    logic [CNT_W-1:0] req1_count;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             busy;
    logic             done;
    logic             grant_id;

    modport master (
        output req0_valid, req0_op, req0_data, req0_count,
        output req1_valid, req1_op, req1_data, req1_count,
        input  req0_ready, req1_ready, a_out, b_out, busy, done, grant_id
    );

    modport slave (
        input  req0_valid, req0_op, req0_data, req0_count,
        input  req1_valid, req1_op, req1_data, req1_count,
        output req0_ready, req1_ready, a_out, b_out, busy, done, grant_id
    );
endinterface

// File: rtl/swap_sched_rr_arb2.sv
// rtl/swap_sched_rr_arb2.sv - two-requester combinational round-robin arbiter
// Purpose: picks one valid requester; on a tie the one that did not win last time.
// Ports: valid0_i, valid1_i, last_grant_i, enable_i in; gnt0_o, gnt1_o, winner_o out.
module rr_arb2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    input  logic enable_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic winner_o
);
    // Requester 0 wins alone, or on a tie when requester 1 won last.
    assign gnt0_o   = enable_i & valid0_i & (~valid1_i | last_grant_i);
    assign gnt1_o   = enable_i & valid1_i & (~valid0_i | ~last_grant_i);
    assign winner_o = gnt1_o;
endmodule

// File: rtl/swap_sched.sv
// rtl/swap_sched.sv - two-register exchange controller with round-robin command intake
// Purpose: accepts LOAD_A/LOAD_B/CLEAR/SWAP_N commands from two requesters and
//          sequences them on registers A and B (IDLE -> EXEC -> DONE).
// Ports: clk, reset_n (async active-low), bus (swap_sched_if.slave: handshakes,
//        a_out/b_out, busy, done, grant_id).
module swap_sched
    import swap_sched_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               CNT_W  = 4,
    parameter logic [WIDTH-1:0] A_INIT = '0,
    parameter logic [WIDTH-1:0] B_INIT = WIDTH'(1)
) (
    input logic         clk,
    input logic         reset_n,
    swap_sched_if.slave bus
);
    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;

    logic gnt0, gnt1, winner, is_idle;

    assign is_idle = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .valid0_i     (bus.req0_valid),
        .valid1_i     (bus.req1_valid),
        .last_grant_i (last_q),
        .enable_i     (is_idle),
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1),
        .winner_o     (winner)
    );

    // State is already IDLE during reset, so ready must also be gated by reset_n.
    assign bus.req0_ready = gnt0 & reset_n;
    assign bus.req1_ready = gnt1 & reset_n;
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.busy       = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.grant_id   = grant_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d = ST_EXEC;
                    grant_d = winner;
                    last_d  = winner;
                    op_d    = op_e'(winner ? bus.req1_op    : bus.req0_op);
                    data_d  = winner ? bus.req1_data  : bus.req0_data;
                    cnt_d   = winner ? bus.req1_count : bus.req0_count;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD_A: begin a_d = data_q; state_d = ST_DONE; end
                    OP_LOAD_B: begin b_d = data_q; state_d = ST_DONE; end
                    OP_CLEAR:  begin a_d = '0; b_d = '0; state_d = ST_DONE; end
                    OP_SWAP_N: begin
                        // N=0 spends one EXEC cycle without touching A/B.
                        if (cnt_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            a_d   = b_q;
                            b_d   = a_q;
                            cnt_d = cnt_q - CNT_W'(1);
                            if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD_A;
            data_q  <= '0;
            cnt_q   <= '0;
            a_q     <= A_INIT;
            b_q     <= B_INIT;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end
endmodule
